dragon_health_tracker: RTL and testbench

Upstream neighbour of the power-up provider. Accumulates spell-to-dragon collision hits once per video frame and maintains the dragon's health. Sequences the dragon through alive, invulnerable-after-hit, dying and dead/respawn states. Emits the one-cycle dragonDead pulse consumed by the power-up provider, plus level outputs for the dragon drawing logic.

---
 rtl/dragon_health_tracker.sv | 129 ++++++++++++
 tb/tb_dragon_health_tracker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dragon_health_tracker.sv
// Dragon health and life-cycle sequencer: latches spell hits per video frame,
// applies damage, and walks ALIVE -> INVULN / DYING -> DEAD -> respawn.
module dragon_health_tracker #(
  parameter int unsigned MAX_HEALTH     = 5,
  parameter int unsigned INVULN_FRAMES  = 30,
  parameter int unsigned DYING_FRAMES   = 60,
  parameter int unsigned RESPAWN_FRAMES = 120
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       spellHit,
  input  logic       powerUpActive,
  output logic       dragonDead,
  output logic       dragonAlive,
  output logic       dragonFlash,
  output logic [3:0] dragonHealth,
  output logic       hitAck
);

  typedef enum logic [1:0] {ST_ALIVE, ST_INVULN, ST_DYING, ST_DEAD} state_e;

  localparam logic [3:0] HEALTH_FULL = 4'(MAX_HEALTH);
  localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES - 1);
  localparam logic [7:0] DYING_LAST  = 8'(DYING_FRAMES - 1);
  localparam logic [7:0] DEAD_LAST   = 8'(RESPAWN_FRAMES - 1);

  state_e     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [3:0] health_q, health_d;
  logic       hit_pending_q, hit_pending_d;
  logic       dead_q, dead_d;
  logic       ack_q, ack_d;
  logic       flash_q, flash_d;
  logic       alive_q, alive_d;
  logic [3:0] damage;
  logic       frame_hit;

  assign damage    = powerUpActive ? 4'd2 : 4'd1;
  assign frame_hit = hit_pending_q | spellHit;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    health_d      = health_q;
    hit_pending_d = 1'b0;
    dead_d        = 1'b0;
    ack_d         = 1'b0;

    unique case (state_q)
      ST_ALIVE: begin
        hit_pending_d = startOfFrame ? 1'b0 : frame_hit;
        if (startOfFrame && frame_hit) begin
          frame_cnt_d = 8'd0;
          if (health_q <= damage) begin
            health_d = 4'd0;
            state_d  = ST_DYING;
            dead_d   = 1'b1;
          end else begin
            health_d = health_q - damage;
            state_d  = ST_INVULN;
            ack_d    = 1'b1;
          end
        end
      end
      ST_INVULN: if (startOfFrame) begin
        if (frame_cnt_q == INVULN_LAST) begin
          state_d     = ST_ALIVE;
          frame_cnt_d = 8'd0;
        end else begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      ST_DYING: if (startOfFrame) begin
        if (frame_cnt_q == DYING_LAST) begin
          state_d     = ST_DEAD;
          frame_cnt_d = 8'd0;
        end else begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      ST_DEAD: if (startOfFrame) begin
        if (frame_cnt_q == DEAD_LAST) begin
          state_d     = ST_ALIVE;
          health_d    = HEALTH_FULL;
          frame_cnt_d = 8'd0;
        end else begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_ALIVE;
    endcase

    // Level outputs follow the next state so they change on the same edge.
    flash_d = (state_d == ST_INVULN) && !frame_cnt_d[2];
    alive_d = (state_d == ST_ALIVE) || (state_d == ST_INVULN);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    if (!resetN) begin
      state_q       <= ST_ALIVE;
      frame_cnt_q   <= 8'd0;
      health_q      <= HEALTH_FULL;
      hit_pending_q <= 1'b0;
      dead_q        <= 1'b0;
      ack_q         <= 1'b0;
      flash_q       <= 1'b0;
      alive_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      health_q      <= health_d;
      hit_pending_q <= hit_pending_d;
      dead_q        <= dead_d;
      ack_q         <= ack_d;
      flash_q       <= flash_d;
      alive_q       <= alive_d;
    end
  end

  assign dragonDead   = dead_q;
  assign dragonAlive  = alive_q;
  assign dragonFlash  = flash_q;
  assign dragonHealth = health_q;
  assign hitAck       = ack_q;

endmodule

// File: tb/tb_dragon_health_tracker.sv
// Directed bench for dragon_health_tracker: hits, power-up damage, invulnerability,
// death/respawn timing and mid-sequence reset, with hand-computed expectations.
module tb_dragon_health_tracker;

  logic       clk = 1'b0;
  logic       resetN, startOfFrame, spellHit, powerUpActive;
  logic       dragonDead, dragonAlive, dragonFlash, hitAck;
  logic [3:0] dragonHealth;

  int checks = 0;
  int errors = 0;
  int dead_pulses = 0;
  int ack_pulses = 0;

  dragon_health_tracker dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .spellHit     (spellHit),
    .powerUpActive(powerUpActive),
    .dragonDead   (dragonDead),
    .dragonAlive  (dragonAlive),
    .dragonFlash  (dragonFlash),
    .dragonHealth (dragonHealth),
    .hitAck       (hitAck)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dragonDead) dead_pulses++;
    if (hitAck)     ack_pulses++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle startOfFrame pulse, optionally with a coincident spellHit.
  task automatic sof(input logic with_hit);
    startOfFrame = 1'b1;
    spellHit     = with_hit;
    tick();
    startOfFrame = 1'b0;
    spellHit     = 1'b0;
  endtask

  // n frames, each with an optional mid-frame spellHit cycle before the frame closes.
  task automatic frames(input int n, input logic with_hit);
    for (int i = 0; i < n; i++) begin
      spellHit = with_hit;
      tick();
      spellHit = 1'b0;
      sof(1'b0);
    end
  endtask

  task automatic hit_frame(input logic pu);
    powerUpActive = pu;
    spellHit = 1'b1;
    tick();
    spellHit = 1'b0;
    sof(1'b0);
    powerUpActive = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
  endtask

  initial begin
    int d0;
    resetN = 1'b1; startOfFrame = 1'b0; spellHit = 1'b0; powerUpActive = 1'b0;
    tick();

    // Reset state
    resetN = 1'b0;
    tick();
    tick();
    check("rst_health", dragonHealth, 5);
    check("rst_alive",  dragonAlive, 1);
    check("rst_dead",   dragonDead, 0);
    check("rst_ack",    hitAck, 0);
    check("rst_flash",  dragonFlash, 0);
    resetN = 1'b1;
    tick();

    // Single hit: 10 hit cycles in one frame count once
    spellHit = 1'b1;
    repeat (10) tick();
    spellHit = 1'b0;
    repeat (3) tick();
    check("pre_sof_health", dragonHealth, 5);
    sof(1'b0);
    check("hit1_health", dragonHealth, 4);
    check("hit1_ack",    hitAck, 1);
    check("hit1_flash",  dragonFlash, 1);
    tick();
    check("hit1_ack_clr", hitAck, 0);

    // Invulnerability with hits every frame; flash follows ~frameCnt[2]
    for (int k = 1; k <= 30; k++) begin
      frames(1, 1'b1);
      if (k == 3)  check("flash_f3",  dragonFlash, 1);
      if (k == 4)  check("flash_f4",  dragonFlash, 0);
      if (k == 8)  check("flash_f8",  dragonFlash, 1);
      if (k == 29) check("flash_f29", dragonFlash, 0);
      if (k == 29) check("inv_alive", dragonAlive, 1);
    end
    check("inv_end_flash",  dragonFlash, 0);
    check("inv_end_health", dragonHealth, 4);
    check("inv_ack_count",  ack_pulses, 1);
    frames(2, 1'b0);
    check("no_leak_health", dragonHealth, 4);

    // Power-up damage from full health
    do_reset();
    hit_frame(1'b1);
    check("pu_health", dragonHealth, 3);
    check("pu_ack",    hitAck, 1);
    frames(30, 1'b0);
    // Coincident spellHit/startOfFrame in ALIVE is applied
    sof(1'b1);
    check("coinc_health", dragonHealth, 2);
    check("coinc_ack",    hitAck, 1);
    frames(30, 1'b0);

    // Fatal boundary: health 2, damage 2
    d0 = dead_pulses;
    powerUpActive = 1'b1;
    sof(1'b1);
    powerUpActive = 1'b0;
    check("kill_health", dragonHealth, 0);
    check("kill_dead",   dragonDead, 1);
    check("kill_alive",  dragonAlive, 0);
    check("kill_ack",    hitAck, 0);
    tick();
    check("kill_dead_clr", dragonDead, 0);

    // DYING 60 + DEAD 120 frames, hits ignored throughout
    frames(179, 1'b1);
    check("dead_f179_alive",  dragonAlive, 0);
    check("dead_f179_health", dragonHealth, 0);
    frames(1, 1'b1);
    check("respawn_alive",  dragonAlive, 1);
    check("respawn_health", dragonHealth, 5);
    check("respawn_dead",   dragonDead, 0);
    check("one_dead_pulse", dead_pulses - d0, 1);

    // Reset during DYING
    hit_frame(1'b1);
    frames(30, 1'b0);
    hit_frame(1'b1);
    frames(30, 1'b0);
    check("h1_health", dragonHealth, 1);
    hit_frame(1'b0);
    check("h1_kill_dead", dragonDead, 1);
    frames(5, 1'b0);
    d0 = dead_pulses;
    resetN = 1'b0;
    tick();
    check("mid_rst_health", dragonHealth, 5);
    check("mid_rst_alive",  dragonAlive, 1);
    check("mid_rst_dead",   dragonDead, 0);
    resetN = 1'b1;
    frames(70, 1'b0);
    check("post_rst_pulses", dead_pulses - d0, 0);
    check("post_rst_health", dragonHealth, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
